// File: rtl/alu_iterative.sv
// ---------------------------------------------------------------------------
// alu_iterative
//
// Multi-cycle execute-stage ALU. Logic, add/sub and compare ops finish in one
// registered cycle. Unsigned multiply, divide and remainder iterate for WIDTH
// cycles. The control path stalls on the start/ready/done handshake.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1. Operands and opcode are sampled on that edge. done pulses for
// exactly one cycle when ALUResult and the flags are updated. ready stays low
// while an iterative op runs. A start seen while ready=0 is dropped, so the
// requester must hold start until it sees ready.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request strobe
//   a, b         operands (WIDTH bits)
//   ALUControl   4-bit opcode
//   ready        idle, able to accept start
//   done         one-cycle completion pulse
//   ALUResult    registered result, held until the next done
//   zero         ALUResult == 0
//   overflow     signed overflow of the last ADD/SUB
//   div_by_zero  last DIVU/REMU had b == 0
//   o_dbg_state  current FSM state (0 = IDLE, 1 = ITER)
// ---------------------------------------------------------------------------
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUControl,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ITER = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  // MUL: r_x is the multiplicand (shifts left), r_y the multiplier (shifts
  // right), r_acc the running product.
  // DIV: r_x holds the dividend and collects quotient bits, r_y is the
  // divisor, and r_acc is the WIDTH+1-bit partial remainder.
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH:0]   r_acc;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_dbz;
  logic             r_done;

  logic             w_accept;
  logic             w_launch;
  logic             w_finish;

  // ---------------- single-cycle datapath (live inputs) ----------------
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_b_zero;
  logic             w_iter_op;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_sc_ovf;
  logic             w_sc_dbz;

  assign w_sum    = a + b;
  assign w_diff   = a - b;
  assign w_b_zero = (b == '0);
  // A zero divisor is resolved at acceptance and never enters ITER.
  assign w_iter_op = (ALUControl == OP_MUL) ||
                     (((ALUControl == OP_DIVU) || (ALUControl == OP_REMU)) && !w_b_zero);

  always_comb begin
    w_sc_result = '0;
    w_sc_ovf    = 1'b0;
    w_sc_dbz    = 1'b0;
    case (ALUControl)
      OP_AND:  w_sc_result = a & b;
      OP_OR:   w_sc_result = a | b;
      OP_ADD: begin
        w_sc_result = w_sum;
        w_sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLTU: w_sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SUB: begin
        w_sc_result = w_diff;
        w_sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR:  w_sc_result = ~(a | b);
      OP_DIVU: begin
        w_sc_result = '1;
        w_sc_dbz    = 1'b1;
      end
      OP_REMU: begin
        w_sc_result = a;
        w_sc_dbz    = 1'b1;
      end
      default: w_sc_result = '0;
    endcase
  end

  // ---------------- iterative step datapath ----------------
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_div_ok;
  logic [WIDTH:0]   w_rem_n;
  logic [WIDTH-1:0] w_quo_n;
  logic [WIDTH-1:0] w_iter_result;

  assign w_mul_acc = r_acc[WIDTH-1:0] + (r_y[0] ? r_x : '0);
  // Restoring step: bring in the next dividend bit and try subtracting the
  // divisor. The extra top bit of the trial difference acts as the borrow.
  assign w_rem_sh  = {r_acc[WIDTH-1:0], r_x[WIDTH-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_y};
  assign w_div_ok  = ~w_trial[WIDTH];
  assign w_rem_n   = w_div_ok ? w_trial : w_rem_sh;
  assign w_quo_n   = {r_x[WIDTH-2:0], w_div_ok};

  always_comb begin
    w_iter_result = '0;
    case (r_op)
      OP_MUL:  w_iter_result = w_mul_acc;
      OP_DIVU: w_iter_result = w_quo_n;
      OP_REMU: w_iter_result = w_rem_n[WIDTH-1:0];
      default: w_iter_result = '0;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_launch  = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (w_iter_op) begin
            w_launch  = 1'b1;
            w_state_n = S_ITER;
          end
        end
      end
      S_ITER: begin
        // The counter reaches 0 on this edge, so the last step is taken now.
        if (r_cnt == CW'(1)) begin
          w_finish  = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept && !w_launch) begin
        r_result <= w_sc_result;
        r_zero   <= (w_sc_result == '0);
        r_ovf    <= w_sc_ovf;
        r_dbz    <= w_sc_dbz;
        r_done   <= 1'b1;
      end

      if (w_launch) begin
        r_op  <= ALUControl;
        r_cnt <= CW'(WIDTH);
        r_x   <= a;
        r_y   <= b;
        r_acc <= '0;
      end

      if (r_state == S_ITER) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_op == OP_MUL) begin
          r_acc <= {1'b0, w_mul_acc};
          r_x   <= {r_x[WIDTH-2:0], 1'b0};
          r_y   <= {1'b0, r_y[WIDTH-1:1]};
        end else begin
          r_acc <= w_rem_n;
          r_x   <= w_quo_n;
        end
        if (w_finish) begin
          r_result <= w_iter_result;
          r_zero   <= (w_iter_result == '0);
          r_ovf    <= 1'b0;
          r_dbz    <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign done        = r_done;
  assign ALUResult   = r_result;
  assign zero        = r_zero;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_iterative.sv
// ---------------------------------------------------------------------------
// tb_alu_iterative
//
// Bench for alu_iterative with WIDTH=32. Each accepted request pushes its
// expected {div_by_zero, overflow, zero, ALUResult} and its expected done
// cycle. A negedge monitor pops and compares on every done.
// ---------------------------------------------------------------------------
module tb_alu_iterative;

  localparam int W = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_ctl;
  logic         ready;
  logic         done;
  logic [W-1:0] alu_result;
  logic         zero;
  logic         overflow;
  logic         div_by_zero;
  logic         dbg_state;

  logic [W+2:0] exp_q[$];
  int           cyc_q[$];
  int           cyc;
  int           n_checks;
  int           n_pass;
  logic [3:0]   op_tab[12];

  alu_iterative #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .ALUControl  (alu_ctl),
    .ready       (ready),
    .done        (done),
    .ALUResult   (alu_result),
    .zero        (zero),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W+2:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W-1:0] r;
    logic         ov;
    logic         dz;
    longint       s;
    logic [63:0]  p;
    r  = '0;
    ov = 1'b0;
    dz = 1'b0;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_ADD: begin
        s  = longint'($signed(x)) + longint'($signed(y));
        r  = x + y;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SLTU: r = (x < y) ? 1 : 0;
      OP_SUB: begin
        s  = longint'($signed(x)) - longint'($signed(y));
        r  = x - y;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SLT:  r = ($signed(x) < $signed(y)) ? 1 : 0;
      OP_NOR:  r = ~(x | y);
      OP_MUL: begin
        p = 64'(x) * 64'(y);
        r = p[W-1:0];
      end
      OP_DIVU: begin
        if (y == 0) begin r = '1; dz = 1'b1; end
        else r = x / y;
      end
      OP_REMU: begin
        if (y == 0) begin r = x; dz = 1'b1; end
        else r = x % y;
      end
      default: r = '0;
    endcase
    return {dz, ov, (r == 0), r};
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [W-1:0] y);
    if (op == OP_MUL) return W;
    if ((op == OP_DIVU || op == OP_REMU) && y != 0) return W;
    return 0;
  endfunction

  // ---------------- driver ----------------
  // Waits for ready, drives one request, and returns 1 ns after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                      input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 0, 1);
    start   = 1'b1;
    alu_ctl = op;
    a       = x;
    b       = y;
    @(posedge clk);
    #1;
    if (track) begin
      exp_q.push_back(model(op, x, y));
      cyc_q.push_back(cyc + latency(op, y));
    end
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [W+2:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        check("result", 64'({div_by_zero, overflow, zero, alu_result}), 64'(e));
        check("latency", 64'(cyc), 64'(ec));
        check("ready_at_done", 64'(ready), 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    op_tab   = '{OP_AND, OP_OR, OP_ADD, OP_SLTU, OP_SUB, OP_SLT, OP_NOR,
                 OP_MUL, OP_DIVU, OP_REMU, 4'b0101, 4'b1111};
    reset   = 1'b1;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    alu_ctl = '0;

    repeat (2) @(negedge clk);
    check("rst_outputs", 64'({ready, done, zero, overflow, div_by_zero, dbg_state}),
          64'(6'b101000));
    check("rst_result", 64'(alu_result), 0);
    reset = 1'b0;

    // ADD overflow into the sign bit
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1);
    drain();

    // back-to-back single-cycle ops give done on consecutive cycles
    send(OP_SUB, 32'd5, 32'd5, 1);
    send(OP_SLT, 32'hFFFF_FFFF, 32'h1, 1);
    drain();

    // SUB overflow boundary
    send(OP_SUB, 32'h8000_0000, 32'h1, 1);
    drain();

    // MUL, plus a start pulse in the middle that must be ignored
    send(OP_MUL, 32'h0001_2345, 32'h0000_1000, 1);
    @(negedge clk);
    check("mul_ready_low", 64'({ready, dbg_state}), 64'(2'b01));
    repeat (5) @(negedge clk);
    start   = 1'b1;
    alu_ctl = OP_ADD;
    a       = 32'h1;
    b       = 32'h1;
    @(negedge clk);
    start = 1'b0;
    check("mul_still_busy", 64'(ready), 0);
    drain();

    // DIVU / REMU
    send(OP_DIVU, 32'd100, 32'd7, 1);
    send(OP_REMU, 32'd100, 32'd7, 1);
    drain();

    // divide by zero completes in one cycle
    send(OP_DIVU, 32'd9, 32'd0, 1);
    send(OP_REMU, 32'd9, 32'd0, 1);
    drain();

    // reset in the middle of an iteration aborts without a done
    send(OP_DIVU, 32'd100, 32'd7, 0);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_outputs", 64'({ready, done, zero, overflow, div_by_zero, dbg_state}),
          64'(6'b101000));
    check("abort_result", 64'(alu_result), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(exp_q.size()), 0);

    send(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 1);
    drain();

    // random mix, including illegal opcodes and zero divisors
    for (int i = 0; i < 24; i++) begin
      logic [3:0]   op;
      logic [W-1:0] x;
      logic [W-1:0] y;
      op = op_tab[$urandom_range(0, 11)];
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      send(op, x, y, 1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
